// File: rtl/pong_scan.sv
// VGA raster scanner for the pong display: 640x480@60 timing plus registered
// per-pixel region flags for paddles, ball, walls and centre net.
module pong_scan #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned PAD1_X   = 16,
  parameter int unsigned PAD2_X   = 616,
  parameter int unsigned PAD_W    = 8,
  parameter int unsigned PAD_H    = 64,
  parameter int unsigned BALL_SZ  = 8,
  parameter int unsigned WALL_T   = 8,
  parameter int unsigned NET_X    = 318,
  parameter int unsigned NET_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] pad1_y,
  input  logic [9:0] pad2_y,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  output logic       hsync,
  output logic       vsync,
  output logic       BRPad1,
  output logic       BRPad2,
  output logic       BRBall,
  output logic       BRWall,
  output logic       BRIW,
  output logic       frame_tick
);

  localparam int unsigned CW      = 10;
  localparam int unsigned AW      = 11;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [CW-1:0] hcnt, vcnt;
  logic [CW-1:0] p1, p2, bx, by;
  logic [AW-1:0] x, y;
  logic h_end_c, v_end_c, frame_end_c, active_c;
  logic hsync_c, vsync_c, pad1_c, pad2_c, ball_c, wall_c, net_c;

  // Half-open span test on 11-bit sums so regions past the edge never wrap.
  function automatic logic in_span(input logic [AW-1:0] v, input logic [AW-1:0] lo,
                                   input logic [AW-1:0] len);
    return (v >= lo) && (v < lo + len);
  endfunction

  always_comb begin
    x           = AW'(hcnt);
    y           = AW'(vcnt);
    h_end_c     = (hcnt == CW'(H_TOTAL - 1));
    v_end_c     = (vcnt == CW'(V_TOTAL - 1));
    frame_end_c = h_end_c && v_end_c;
    active_c    = (hcnt < CW'(H_ACTIVE)) && (vcnt < CW'(V_ACTIVE));
    hsync_c     = !((hcnt >= CW'(H_ACTIVE + H_FP)) && (hcnt < CW'(H_ACTIVE + H_FP + H_SYNC)));
    vsync_c     = !((vcnt >= CW'(V_ACTIVE + V_FP)) && (vcnt < CW'(V_ACTIVE + V_FP + V_SYNC)));
    wall_c      = (y < AW'(WALL_T)) || (y >= AW'(V_ACTIVE - WALL_T));
    pad1_c      = in_span(x, AW'(PAD1_X), AW'(PAD_W)) && in_span(y, AW'(p1), AW'(PAD_H));
    pad2_c      = in_span(x, AW'(PAD2_X), AW'(PAD_W)) && in_span(y, AW'(p2), AW'(PAD_H));
    ball_c      = in_span(x, AW'(bx), AW'(BALL_SZ)) && in_span(y, AW'(by), AW'(BALL_SZ));
    // Dashed net: 16-line segments, suppressed where the walls are drawn.
    net_c       = in_span(x, AW'(NET_X), AW'(NET_W)) && !vcnt[4] && !wall_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_end_c) begin
      hcnt <= '0;
      vcnt <= v_end_c ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  // Positions are sampled once per frame so a frame never tears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1 <= '0;
      p2 <= '0;
      bx <= '0;
      by <= '0;
    end else if (frame_end_c) begin
      p1 <= pad1_y;
      p2 <= pad2_y;
      bx <= ball_x;
      by <= ball_y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      BRPad1     <= 1'b0;
      BRPad2     <= 1'b0;
      BRBall     <= 1'b0;
      BRWall     <= 1'b0;
      BRIW       <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      hsync      <= hsync_c;
      vsync      <= vsync_c;
      BRPad1     <= active_c && pad1_c;
      BRPad2     <= active_c && pad2_c;
      BRBall     <= active_c && ball_c;
      BRWall     <= active_c && wall_c;
      BRIW       <= active_c && net_c;
      frame_tick <= frame_end_c;
    end
  end

endmodule

// File: tb/tb_pong_scan.sv
// Bench for pong_scan: a full-size instance for line timing and a scaled-down
// instance so whole frames (latching, vsync, clipping) fit a short run.
module tb_pong_scan;

  typedef struct packed {
    int ha, hf, hs, hb, va, vf, vs, vb, p1x, p2x, pw, ph, bs, wt, nx, nw;
  } cfg_t;

  typedef struct packed {
    logic [9:0] p1, p2, bx, by;
  } pos_t;

  localparam cfg_t CD = '{640, 16, 96, 48, 480, 10, 2, 33, 16, 616, 8, 64, 8, 8, 318, 4};
  localparam cfg_t CS = '{40, 4, 6, 6, 40, 3, 2, 3, 2, 34, 3, 6, 4, 2, 19, 2};
  localparam int FD = (CD.ha + CD.hf + CD.hs + CD.hb) * (CD.va + CD.vf + CD.vs + CD.vb);
  localparam int FS = (CS.ha + CS.hf + CS.hs + CS.hb) * (CS.va + CS.vf + CS.vs + CS.vb);
  localparam logic [7:0] RST_OUT = 8'b1100_0000;

  logic clk = 1'b0;
  logic rst;
  logic [9:0] pad1_y, pad2_y, ball_x, ball_y;
  logic hsync_d, vsync_d, pad1_d, pad2_d, ball_d, wall_d, net_d, tick_d;
  logic hsync_s, vsync_s, pad1_s, pad2_s, ball_s, wall_s, net_s, tick_s;

  int checks = 0;
  int errors = 0;
  int t_d = 0, t_s = 0;
  pos_t cur_d = '0, pend_d = '0, cur_s = '0, pend_s = '0;

  always #5 clk = ~clk;

  pong_scan dut_d (
    .clk(clk), .rst(rst), .pad1_y(pad1_y), .pad2_y(pad2_y), .ball_x(ball_x), .ball_y(ball_y),
    .hsync(hsync_d), .vsync(vsync_d), .BRPad1(pad1_d), .BRPad2(pad2_d), .BRBall(ball_d),
    .BRWall(wall_d), .BRIW(net_d), .frame_tick(tick_d)
  );

  pong_scan #(
    .H_ACTIVE(CS.ha), .H_FP(CS.hf), .H_SYNC(CS.hs), .H_BP(CS.hb),
    .V_ACTIVE(CS.va), .V_FP(CS.vf), .V_SYNC(CS.vs), .V_BP(CS.vb),
    .PAD1_X(CS.p1x), .PAD2_X(CS.p2x), .PAD_W(CS.pw), .PAD_H(CS.ph),
    .BALL_SZ(CS.bs), .WALL_T(CS.wt), .NET_X(CS.nx), .NET_W(CS.nw)
  ) dut_s (
    .clk(clk), .rst(rst), .pad1_y(pad1_y), .pad2_y(pad2_y), .ball_x(ball_x), .ball_y(ball_y),
    .hsync(hsync_s), .vsync(vsync_s), .BRPad1(pad1_s), .BRPad2(pad2_s), .BRBall(ball_s),
    .BRWall(wall_s), .BRIW(net_s), .frame_tick(tick_s)
  );

  function automatic bit in_span(int v, int lo, int len);
    return (v >= lo) && (v < lo + len);
  endfunction

  // Expected {hsync,vsync,pad1,pad2,ball,wall,net,tick} for the p-th pixel since reset.
  function automatic logic [7:0] model(cfg_t c, int p, pos_t q);
    int ht, vt, x, y;
    bit act, wall;
    logic [7:0] r;
    ht   = c.ha + c.hf + c.hs + c.hb;
    vt   = c.va + c.vf + c.vs + c.vb;
    x    = p % ht;
    y    = (p / ht) % vt;
    act  = (x < c.ha) && (y < c.va);
    wall = (y < c.wt) || (y >= c.va - c.wt);
    r[7] = !(x >= c.ha + c.hf && x < c.ha + c.hf + c.hs);
    r[6] = !(y >= c.va + c.vf && y < c.va + c.vf + c.vs);
    r[5] = act && in_span(x, c.p1x, c.pw) && in_span(y, int'(q.p1), c.ph);
    r[4] = act && in_span(x, c.p2x, c.pw) && in_span(y, int'(q.p2), c.ph);
    r[3] = act && in_span(x, int'(q.bx), c.bs) && in_span(y, int'(q.by), c.bs);
    r[2] = act && wall;
    r[1] = act && in_span(x, c.nx, c.nw) && ((y / 16) % 2 == 0) && !wall;
    r[0] = (p % (ht * vt)) == (ht * vt - 1);
    return r;
  endfunction

  task automatic chk(input string tag, input int pix, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s pixel %0d: observed %b expected %b (hs,vs,p1,p2,ball,wall,net,tick)",
             tag, pix, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Frame-level position model: what the scanner will be drawing for each frame.
  always @(posedge clk) begin
    if (rst) begin
      t_d = 0; cur_d = '0; pend_d = '0;
      t_s = 0; cur_s = '0; pend_s = '0;
    end else begin
      if (t_d > 0 && t_d % FD == 0) cur_d = pend_d;
      if (t_d % FD == FD - 1) pend_d = {pad1_y, pad2_y, ball_x, ball_y};
      t_d++;
      if (t_s > 0 && t_s % FS == 0) cur_s = pend_s;
      if (t_s % FS == FS - 1) pend_s = {pad1_y, pad2_y, ball_x, ball_y};
      t_s++;
    end
  end

  always @(negedge clk) begin
    chk("full", t_d - 1, {hsync_d, vsync_d, pad1_d, pad2_d, ball_d, wall_d, net_d, tick_d},
        (t_d == 0) ? RST_OUT : model(CD, t_d - 1, cur_d));
    chk("scaled", t_s - 1, {hsync_s, vsync_s, pad1_s, pad2_s, ball_s, wall_s, net_s, tick_s},
        (t_s == 0) ? RST_OUT : model(CS, t_s - 1, cur_s));
  end

  task automatic randomize_pos();
    pad1_y = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 45));
    pad2_y = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 45));
    ball_x = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 45));
    ball_y = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 45));
  endtask

  task automatic wait_tick_s(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (tick_s !== 1'b1 && n < FS + 100);
  endtask

  task automatic wait_hsync_d(input logic level, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (hsync_d !== level && n < 2000);
  endtask

  initial begin
    int n, w;
    rst = 1'b1;
    pad1_y = '0; pad2_y = '0; ball_x = '0; ball_y = '0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    // Line timing on the full-size scanner.
    wait_hsync_d(1'b0, n);
    chk_int("hsync_first_fall", n, 657);
    wait_hsync_d(1'b1, w);
    chk_int("hsync_low_width", w, 96);
    wait_hsync_d(1'b0, n);
    wait_hsync_d(1'b1, w);
    chk_int("hsync_period", n + w, 800);

    // Paddles plus ball clipped in the bottom-right corner (over the wall).
    @(negedge clk); #2;
    pad1_y = 10'd4; pad2_y = 10'd30; ball_x = 10'd38; ball_y = 10'd38;
    wait_tick_s(n);

    // Ball moved mid-frame must only appear from the next frame.
    repeat (1300) @(negedge clk);
    #2 ball_x = 10'd10;
    wait_tick_s(n);
    chk_int("frame_tick_period", n + 1300, FS);

    // Ball overlapping the left paddle origin.
    @(negedge clk); #2;
    ball_x = 10'd2; ball_y = 10'd4;
    wait_tick_s(n);
    wait_tick_s(n);
    chk_int("frame_tick_period2", n, FS);

    // Random positions changed at random points in the frame.
    for (int f = 0; f < 10; f++) begin
      repeat ($urandom_range(1, 3)) begin
        repeat ($urandom_range(50, 1200)) @(negedge clk);
        #2 randomize_pos();
      end
    end

    // Reset in the middle of a scan.
    repeat ($urandom_range(100, 2000)) @(negedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    wait_hsync_d(1'b0, n);
    chk_int("hsync_fall_after_reset", n, 657);
    randomize_pos();
    wait_tick_s(n);
    wait_tick_s(n);
    chk_int("frame_tick_period3", n, FS);
    repeat (200) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_scan.md
Name: pong_scan

Overview:
- Raster-side producer of the per-pixel region flags consumed by the colour-lookup stage.
- Generates 640x480@60 VGA timing from the 25 MHz pixel clock.
- Compares the current scan position against frame-latched paddle and ball positions, and emits registered region flags aligned with hsync/vsync.
- Sits between the game-logic block (position source) and the colour stage/VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync pulse width
V_BP, 33, vertical back porch
PAD1_X, 16, left paddle x origin
PAD2_X, 616, right paddle x origin
PAD_W, 8, paddle width
PAD_H, 64, paddle height
BALL_SZ, 8, ball side length
WALL_T, 8, top/bottom wall thickness
NET_X, 318, centre net x origin
NET_W, 4, centre net width

Ports:
clk  in  1  25 MHz pixel clock
rst  in  1  reset, asynchronous, active-high
pad1_y  in  10  left paddle top y
pad2_y  in  10  right paddle top y
ball_x  in  10  ball left x
ball_y  in  10  ball top y
hsync  out  1  horizontal sync, active low
vsync  out  1  vertical sync, active low
BRPad1  out  1  pixel inside left paddle
BRPad2  out  1  pixel inside right paddle
BRBall  out  1  pixel inside ball
BRWall  out  1  pixel inside top/bottom wall
BRIW  out  1  pixel inside centre (inner) net
frame_tick  out  1  one-cycle pulse at end of frame

Behaviour:
- One clock domain, clk. rst is asynchronous and active-high.
- Reset state: hcnt=0, vcnt=0, hsync=1, vsync=1, all BR* flags=0, frame_tick=0, latched positions=0.
- Counters:
  - hcnt runs 0..799 (H total 800) and wraps to 0.
  - vcnt increments when hcnt wraps, runs 0..524 (V total 525), and wraps to 0.
- Output latency: every output is registered and reflects the counter value of the previous cycle. hsync, vsync and the flags therefore stay mutually aligned.
- hsync=0 iff hcnt in [656,751]. vsync=0 iff vcnt in [490,491].
- active = hcnt<640 and vcnt<480. When active=0, all BR* flags are 0.
- Position latching:
  - pad1_y, pad2_y, ball_x and ball_y are sampled only on the cycle where hcnt=799 and vcnt=524.
  - frame_tick=1 on the following cycle.
  - Positions never change mid-frame (no tearing). Input changes at any other time take effect only from the next frame.
- Region rules, with x=hcnt, y=vcnt and latched positions:
  - BRWall: y<WALL_T or y>=480-WALL_T.
  - BRPad1: PAD1_X<=x<PAD1_X+PAD_W and p1<=y<p1+PAD_H.
  - BRPad2: same as BRPad1 with PAD2_X and p2.
  - BRBall: bx<=x<bx+BALL_SZ and by<=y<by+BALL_SZ.
  - BRIW: NET_X<=x<NET_X+NET_W and y[4]=0 and not wall (dashed net, 16-line segments).
- Width: all sums are computed 11 bits wide, so no wrap. A region extending past 639/479 is clipped by active; it never wraps to x/y=0.
- Flags are independent; any combination may be 1 simultaneously (e.g. ball over paddle gives BRPad1=BRBall=1). Priority is resolved by the colour stage.
- Reset mid-frame: all state returns to reset values immediately. The frame restarts from hcnt=vcnt=0 with positions=0 until the next end-of-frame sample.

Test Plan:
- Reset: assert rst for 3 cycles mid-scan -> hsync=vsync=1, all flags=0, frame_tick=0; after release, hsync falls exactly 657 cycles later.
- Line timing: free run one line -> hsync low for exactly 96 cycles; rising edge 800 cycles after previous rising edge.
- Frame timing: run two frames -> vsync low for exactly 1600 cycles (2 lines); frame_tick period 420000 cycles.
- Paddle/wall: pad1_y=100 latched -> BRPad1=1 for x 16..23, y 100..163 only; BRWall=1 on lines 0..7 and 472..479; a line-0 pixel inside the paddle x-range also shows BRWall.
- Ball clip/overlap: ball_x=636, ball_y=476 -> BRBall=1 only for x 636..639, y 476..479 (no wrap); BRWall also 1 there. ball_x=16, ball_y=100, pad1_y=100 -> BRPad1=BRBall=1 at (16,100).
- Latch timing: change ball_x from 200 to 300 at vcnt=240 -> remainder of frame still draws at 200; next frame draws at 300. Net visible at x 318..321, lines 16..31 off, lines 32..47 on.
